// File: rtl/hc138_ack_pkg.sv
// Shared types and helpers for the HC138-style acknowledge decoder.
//   state_t    : FSM state encoding (IDLE, QUAL, ACK, WAIT_REL)
//   DOUT_IDLE  : all acknowledge lines released (active-low)
//   onehot_n() : active-low 3-to-8 decode of a channel index
package hc138_ack_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    ACK      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [7:0] DOUT_IDLE = 8'hFF;

  function automatic logic [7:0] onehot_n(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/hc138_ack_decoder_if.sv
// Request/acknowledge bundle between an HC148-style priority encoder and the
// acknowledge decoder.
//   EI, GS, din : encoder enable, group select and code (all active-low)
//   dout        : one-hot active-low acknowledge
//   busy        : acknowledge in progress or waiting for release
//   last_idx    : index of the most recent acknowledge
//   served      : wrapping acknowledge count
// master = encoder/request side, slave = decoder.
interface hc138_ack_decoder_if;
  logic       EI;
  logic       GS;
  logic [2:0] din;
  logic [7:0] dout;
  logic       busy;
  logic [2:0] last_idx;
  logic [7:0] served;

  modport master (
    output EI, GS, din,
    input  dout, busy, last_idx, served
  );

  modport slave (
    input  EI, GS, din,
    output dout, busy, last_idx, served
  );
endinterface

// File: rtl/hc_down_counter.sv
// Loadable 8-bit down-counter with zero flag; used to time the acknowledge pulse.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (highest priority)
//   load     : load load_val
//   dec      : decrement, saturating at zero
//   zero     : count is zero
module hc_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/hc138_ack_decoder.sv
// Receiving end of an HC148-style priority-encoder request. The active-low code
// must be seen unchanged with GS=0 for STABLE_CYCLES clocks, then one active-low
// acknowledge line is pulsed for ACK_CYCLES clocks, after which the request must
// be released (GS=1) before another acknowledge can be issued. EI=1 aborts.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of hc138_ack_decoder_if (EI/GS/din in;
//              dout/busy/last_idx/served out, all registered)
module hc138_ack_decoder
  import hc138_ack_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2,  // 1..15
  parameter int unsigned ACK_CYCLES    = 4   // 1..255
) (
  input  logic                 clk,
  input  logic                 rst,
  hc138_ack_decoder_if.slave   bus
);

  localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);
  localparam logic [7:0] ACK_LOAD   = 8'(ACK_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cand_q, cand_d;
  logic [3:0] qcnt_q, qcnt_d;
  logic [7:0] dout_q, dout_d;
  logic       busy_q, busy_d;
  logic [2:0] last_idx_q, last_idx_d;
  logic [7:0] served_q, served_d;

  logic       acnt_clr, acnt_load, acnt_dec, acnt_zero;
  logic       ack_go;
  logic [2:0] ack_code;
  logic [3:0] qcnt_inc;

  hc_down_counter u_ack_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (acnt_clr),
    .load     (acnt_load),
    .load_val (ACK_LOAD),
    .dec      (acnt_dec),
    .zero     (acnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    qcnt_d     = qcnt_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    last_idx_d = last_idx_q;
    served_d   = served_q;
    acnt_clr   = 1'b0;
    acnt_load  = 1'b0;
    acnt_dec   = 1'b0;
    ack_go     = 1'b0;
    ack_code   = cand_q;
    qcnt_inc   = qcnt_q + 4'd1;

    if (bus.EI) begin
      // Abort overrides every state, including an acknowledge in progress.
      state_d  = IDLE;
      dout_d   = DOUT_IDLE;
      busy_d   = 1'b0;
      qcnt_d   = 4'd0;
      acnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.GS) begin
            cand_d = bus.din;
            qcnt_d = 4'd1;
            if (STABLE_LIM == 4'd1) begin
              ack_go   = 1'b1;
              ack_code = bus.din;
            end else begin
              state_d = QUAL;
            end
          end
        end
        QUAL: begin
          if (bus.GS) begin
            state_d = IDLE;
            qcnt_d  = 4'd0;
          end else if (bus.din == cand_q) begin
            qcnt_d = qcnt_inc;
            if (qcnt_inc == STABLE_LIM) begin
              ack_go = 1'b1;
            end
          end else begin
            // Code moved: restart qualification on the new value.
            cand_d = bus.din;
            qcnt_d = 4'd1;
          end
        end
        ACK: begin
          if (acnt_zero) begin
            state_d = WAIT_REL;
            dout_d  = DOUT_IDLE;
          end else begin
            acnt_dec = 1'b1;
          end
        end
        WAIT_REL: begin
          if (bus.GS) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (ack_go) begin
      state_d    = ACK;
      dout_d     = onehot_n(~ack_code);
      last_idx_d = ~ack_code;
      served_d   = served_q + 8'd1;
      busy_d     = 1'b1;
      qcnt_d     = 4'd0;
      acnt_load  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= 3'd0;
      qcnt_q     <= 4'd0;
      dout_q     <= DOUT_IDLE;
      busy_q     <= 1'b0;
      last_idx_q <= 3'd0;
      served_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      qcnt_q     <= qcnt_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      last_idx_q <= last_idx_d;
      served_q   <= served_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.busy     = busy_q;
  assign bus.last_idx = last_idx_q;
  assign bus.served   = served_q;

endmodule
